// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// Holds the FSM state enum, the Booth op recoding and the count width.
package mul_pkg;

   localparam int MUL_BITS = 32;
   localparam int COUNT_W  = $clog2(MUL_BITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_ADD,
      OP_SUB
   } booth_op_t;

   // Radix-2 Booth recoding of the {Q[0], q_m1} pair.
   function automatic booth_op_t booth_decode(
      input logic q0,
      input logic qm1
   );
      booth_op_t op;
      op = OP_NOP;
      unique case ({q0, qm1})
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_add_sub.sv
// BITS-wide add/subtract: 4-bit lookahead groups, carries rippling between
// groups. Ports: a, b operands; sub inverts b and sets carry-in; sum; ovf.
module booth_add_sub #(
   parameter int BITS = 32
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            sub,
   output logic [BITS-1:0] sum,
   output logic            ovf
);

   localparam int GRP = 4;

   logic [BITS-1:0] bx;
   logic [BITS-1:0] g;
   logic [BITS-1:0] p;
   logic [BITS:0]   carry;

   assign bx = sub ? ~b : b;
   assign g  = a & bx;
   assign p  = a ^ bx;

   // Each carry is formed from the generate/propagate terms of its own
   // group plus that group's carry-in.
   always_comb begin
      logic [BITS:0] cv;
      logic          acc;
      logic          pp;
      int            base;
      cv    = '0;
      cv[0] = sub;
      acc   = 1'b0;
      pp    = 1'b1;
      base  = 0;
      for (int i = 0; i < BITS; i++) begin
         base = (i / GRP) * GRP;
         acc  = 1'b0;
         pp   = 1'b1;
         for (int j = GRP - 1; j >= 0; j--) begin
            if (base + j <= i) begin
               acc = acc | (g[base+j] & pp);
               pp  = pp & p[base+j];
            end
         end
         cv[i+1] = acc | (pp & cv[base]);
      end
      carry = cv;
   end

   assign sum = p ^ carry[BITS-1:0];
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign ovf = carry[BITS] ^ carry[BITS-1];

endmodule

// File: rtl/booth_sequential_multiplier.sv
// Radix-2 Booth sequential multiplier, signed BITS x BITS -> 2*BITS.
// Ports: clk; clr (async, active-high); start; multiplicand; multiplier;
// busy (RUN); done (1-cycle pulse); product_hi/product_lo (registered).
// Option: MUL_ZERO_BYPASS_EN -- a zero operand skips RUN, done next cycle.
module booth_sequential_multiplier
   import mul_pkg::*;
#(
   parameter int BITS = MUL_BITS
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic [BITS-1:0] multiplicand,
   input  logic [BITS-1:0] multiplier,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] product_hi,
   output logic [BITS-1:0] product_lo
);

   localparam int CW = $clog2(BITS + 1);

   mul_state_t state_q;
   mul_state_t state_d;

   logic [BITS-1:0] m_q;
   logic [BITS-1:0] a_q;
   logic [BITS-1:0] q_q;
   logic            qm1_q;
   logic [CW-1:0]   cnt_q;

   logic            load;
   logic            step;
   logic            zload;
   logic            last;
   logic            bypass;

   booth_op_t       op;
   logic [BITS-1:0] sum;
   logic            ovf;
   logic [BITS-1:0] a_mid;
   logic            msb_in;
   logic [BITS-1:0] a_nxt;
   logic [BITS-1:0] q_nxt;

`ifdef MUL_ZERO_BYPASS_EN
   logic zero_op;
   assign zero_op = (multiplicand == '0) || (multiplier == '0);
   assign bypass  = zero_op;
`else
   assign bypass  = 1'b0;
`endif

   assign last = (cnt_q == CW'(1));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      zload   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (bypass) begin
                  state_d = DONE;
                  zload   = 1'b1;
               end else begin
                  state_d = RUN;
                  load    = 1'b1;
               end
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign op = booth_decode(q_q[0], qm1_q);

   booth_add_sub #(
      .BITS (BITS)
   ) u_add_sub (
      .a   (a_q),
      .b   (m_q),
      .sub (op == OP_SUB),
      .sum (sum),
      .ovf (ovf)
   );

   // The shift uses the sign of the true (BITS+1)-bit sum, so an add/sub
   // that overflows BITS (e.g. subtracting the most-negative M) still
   // shifts in the right sign and A never needs an extra bit.
   always_comb begin
      a_mid  = a_q;
      msb_in = a_q[BITS-1];
      if (op != OP_NOP) begin
         a_mid  = sum;
         msb_in = sum[BITS-1] ^ ovf;
      end
      a_nxt = {msb_in, a_mid[BITS-1:1]};
      q_nxt = {a_mid[0], q_q[BITS-1:1]};
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         m_q        <= '0;
         a_q        <= '0;
         q_q        <= '0;
         qm1_q      <= 1'b0;
         cnt_q      <= '0;
         product_hi <= '0;
         product_lo <= '0;
      end else begin
         if (load) begin
            m_q   <= multiplicand;
            a_q   <= '0;
            q_q   <= multiplier;
            qm1_q <= 1'b0;
            cnt_q <= CW'(BITS);
         end else if (step) begin
            a_q   <= a_nxt;
            q_q   <= q_nxt;
            qm1_q <= q_q[0];
            cnt_q <= cnt_q - CW'(1);
            if (last) begin
               product_hi <= a_nxt;
               product_lo <= q_nxt;
            end
         end
         if (zload) begin
            product_hi <= '0;
            product_lo <= '0;
         end
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Directed bench for booth_sequential_multiplier (BITS = 32).
// Vector table plus hand sequences for hold, restart and clr abort.
module tb_booth_sequential_multiplier;

`ifdef MUL_ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        done;
   logic [31:0] product_hi;
   logic [31:0] product_lo;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   booth_sequential_multiplier #(
      .BITS (32)
   ) dut (
      .clk          (clk),
      .clr          (clr),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product_hi   (product_hi),
      .product_lo   (product_lo)
   );

   typedef struct {
      logic [31:0] m;
      logic [31:0] q;
      logic [63:0] p;
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] m,
                                  input logic [31:0] q);
      int lat;
      lat = 33;
      if (BYPASS && ((m == 32'd0) || (q == 32'd0))) lat = 1;
      return lat;
   endfunction

   task automatic run_one(input logic [31:0] m, input logic [31:0] q,
                          input int peek,
                          output logic [63:0] prod, output int lat,
                          output bit saw_busy,
                          output logic [63:0] peek_p);
      @(negedge clk);
      start        = 1'b1;
      multiplicand = m;
      multiplier   = q;
      @(posedge clk);
      #1;
      start        = 1'b0;
      multiplicand = 32'hDEAD_BEEF;
      multiplier   = 32'h1234_5678;
      lat      = -1;
      saw_busy = 1'b0;
      peek_p   = '0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
         if (c == peek) peek_p = {product_hi, product_lo};
         if (done) begin
            lat = c;
            break;
         end
      end
      prod = {product_hi, product_lo};
   endtask

   initial begin
      logic [63:0] prod;
      logic [63:0] peek_p;
      logic [63:0] p1;
      logic [63:0] p2;
      int          lat;
      int          ndone;
      int          d1;
      int          d2;
      bit          sb;

      vecs[0]  = '{32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "7x-3"};
      vecs[1]  = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minxmin"};
      vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "-1x-1"};
      vecs[3]  = '{32'h7FFF_FFFF, 32'd2,        64'h0000_0000_FFFF_FFFE, "maxx2"};
      vecs[4]  = '{32'd5,        32'd6,        64'h0000_0000_0000_001E, "5x6"};
      vecs[5]  = '{32'd0,        32'd123,      64'h0,                   "0x123"};
      vecs[6]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "maxxmax"};
      vecs[7]  = '{32'hFFFF_FFFB, 32'd7,        64'hFFFF_FFFF_FFFF_FFDD, "-5x7"};
      vecs[8]  = '{32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000, "minx1"};
      vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "minx-1"};
      vecs[10] = '{32'h1234_5678, 32'h10,       64'h0000_0001_2345_6780, "shift4"};
      vecs[11] = '{32'd1234,     32'd0,        64'h0,                   "1234x0"};

      clr          = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(product_hi), 64'd0);
      chk("rst_lo", 64'(product_lo), 64'd0);
      clr = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_one(vecs[i].m, vecs[i].q, 0, prod, lat, sb, peek_p);
         chk({vecs[i].name, "_lat"}, 64'(lat),
             64'(exp_lat(vecs[i].m, vecs[i].q)));
         chk({vecs[i].name, "_hi"}, 64'(prod[63:32]), 64'(vecs[i].p[63:32]));
         chk({vecs[i].name, "_lo"}, 64'(prod[31:0]), 64'(vecs[i].p[31:0]));
         chk({vecs[i].name, "_busy"}, 64'(sb),
             64'(exp_lat(vecs[i].m, vecs[i].q) > 1));
         @(negedge clk);
         chk({vecs[i].name, "_pulse"}, 64'(done), 64'd0);
      end

      // Result of the previous multiply stays visible during the next run.
      run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, prod, lat, sb, peek_p);
      chk("hold_first", prod, 64'd1);
      run_one(32'h7FFF_FFFF, 32'd2, 5, prod, lat, sb, peek_p);
      chk("hold_mid", peek_p, 64'd1);
      chk("hold_second", prod, 64'h0000_0000_FFFF_FFFE);

      // Start held high: later operands ignored until back in IDLE.
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 32'd3;
      multiplier   = 32'd4;
      @(posedge clk);
      ndone = 0;
      d1    = 0;
      d2    = 0;
      p1    = '0;
      p2    = '0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               d1 = k;
               p1 = {product_hi, product_lo};
            end else if (ndone == 2) begin
               d2 = k;
               p2 = {product_hi, product_lo};
            end
         end
         if (k >= 68) begin
            start = 1'b0;
         end else begin
            multiplicand = 32'(k + 10);
            multiplier   = 32'd2;
         end
      end
      chk("b2b_count", 64'(ndone), 64'd2);
      chk("b2b_d1", 64'(d1), 64'd33);
      chk("b2b_d2", 64'(d2), 64'd67);
      chk("b2b_p1", p1, 64'd12);
      chk("b2b_p2", p2, 64'd88);

      // clr in the middle of a run.
      @(negedge clk);
      start        = 1'b1;
      multiplicand = 32'd9;
      multiplier   = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("clr_pre_busy", 64'(busy), 64'd1);
      #1;
      clr = 1'b1;
      #1;
      chk("clr_busy", 64'(busy), 64'd0);
      chk("clr_done", 64'(done), 64'd0);
      chk("clr_hi", 64'(product_hi), 64'd0);
      chk("clr_lo", 64'(product_lo), 64'd0);
      @(negedge clk);
      clr = 1'b0;
      run_one(32'd5, 32'd6, 0, prod, lat, sb, peek_p);
      chk("post_clr_lat", 64'(lat), 64'd33);
      chk("post_clr_prod", prod, 64'd30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
